// File: rtl/cdc_clear_seq_responder.sv
// ----------------------------------------------------------------------------
// cdc_clear_seq_responder
//   Responder end of the clear-sequence protocol. Takes one clear-sequence
//   phase command at a time from the destination half of a 4-phase CDC link,
//   performs the matching local action (isolate / clear / release) on the
//   reset domain it lives in, and returns one acknowledge carrying the same
//   phase into the source half of the return link.
//
//   The phase type is declared in cdc_reset_ctrlr_pkg, shared with the
//   controller side of the protocol.
// ----------------------------------------------------------------------------

package cdc_reset_ctrlr_pkg;

   // Clear-sequence phases; values are absolute and may arrive in any order.
   typedef enum logic [1:0] {
      CLEAR_PHASE_IDLE       = 2'd0,
      CLEAR_PHASE_ISOLATE    = 2'd1,
      CLEAR_PHASE_CLEAR      = 2'd2,
      CLEAR_PHASE_POST_CLEAR = 2'd3
   } clear_seq_phase_e;

endpackage : cdc_reset_ctrlr_pkg

module cdc_clear_seq_responder #(
   parameter int unsigned CLEAR_CYCLES = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   // command from the CDC destination half
   input  logic [1:0] req_phase_i,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   // acknowledge towards the CDC source half
   output logic [1:0] ack_phase_o,
   output logic       ack_valid_o,
   input  logic       ack_ready_i,
   // local reset-domain control
   output logic       isolate_o,
   input  logic       isolate_ack_i,
   output logic       clear_o
);

   import cdc_reset_ctrlr_pkg::*;

   // Counter wide enough to hold CLEAR_CYCLES-1; derived, never overridden.
   localparam int unsigned CntWidth = (CLEAR_CYCLES < 1) ? 1 : $clog2(CLEAR_CYCLES + 1);

   // The counter starts one below the hold length because the load cycle
   // itself is the first cycle clear_o is high.
   localparam logic [CntWidth-1:0] CntLoad = CntWidth'(CLEAR_CYCLES - 1);

   // Reject a zero-length clear pulse at elaboration.
   if (CLEAR_CYCLES < 1) begin : g_param_check
      $error("cdc_clear_seq_responder: CLEAR_CYCLES must be >= 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE              = 3'd0,
      ST_WAIT_ISO_ASSERT   = 3'd1,
      ST_CLEARING          = 3'd2,
      ST_WAIT_ISO_DEASSERT = 3'd3,
      ST_SEND_ACK          = 3'd4
   } state_e;

   state_e             state_q,     state_d;
   clear_seq_phase_e   phase_q,     phase_d;
   clear_seq_phase_e   ack_phase_q, ack_phase_d;
   logic               ack_valid_q, ack_valid_d;
   logic               isolate_q,   isolate_d;
   logic               clear_q,     clear_d;
   logic [CntWidth-1:0] cnt_q,      cnt_d;

   clear_seq_phase_e   req_phase;

   assign req_phase = clear_seq_phase_e'(req_phase_i);

   // State and output registers; async reset returns everything to idle and
   // drops any acknowledge that was still pending.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         phase_q     <= CLEAR_PHASE_IDLE;
         ack_phase_q <= CLEAR_PHASE_IDLE;
         ack_valid_q <= 1'b0;
         isolate_q   <= 1'b0;
         clear_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         ack_phase_q <= ack_phase_d;
         ack_valid_q <= ack_valid_d;
         isolate_q   <= isolate_d;
         clear_q     <= clear_d;
         cnt_q       <= cnt_d;
      end
   end

   // Next-state and registered-output logic. Every transition into SEND_ACK
   // raises ack_valid together with the latched phase, so the acknowledge is
   // visible the cycle after the action completes.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      ack_phase_d = ack_phase_q;
      ack_valid_d = ack_valid_q;
      isolate_d   = isolate_q;
      clear_d     = clear_q;
      cnt_d       = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               phase_d = req_phase;
               unique case (req_phase)
                  CLEAR_PHASE_ISOLATE: begin
                     isolate_d = 1'b1;
                     state_d   = ST_WAIT_ISO_ASSERT;
                  end
                  CLEAR_PHASE_CLEAR: begin
                     // Clearing always implies isolation, even without a
                     // preceding ISOLATE command.
                     isolate_d = 1'b1;
                     clear_d   = 1'b1;
                     cnt_d     = CntLoad;
                     state_d   = ST_CLEARING;
                  end
                  CLEAR_PHASE_POST_CLEAR: begin
                     isolate_d = 1'b0;
                     clear_d   = 1'b0;
                     state_d   = ST_WAIT_ISO_DEASSERT;
                  end
                  default: begin
                     // IDLE phase: nothing to do locally, acknowledge at once.
                     ack_valid_d = 1'b1;
                     ack_phase_d = req_phase;
                     state_d     = ST_SEND_ACK;
                  end
               endcase
            end
         end

         ST_WAIT_ISO_ASSERT: begin
            if (isolate_ack_i) begin
               ack_valid_d = 1'b1;
               ack_phase_d = phase_q;
               state_d     = ST_SEND_ACK;
            end
         end

         ST_CLEARING: begin
            if (cnt_q == '0) begin
               clear_d     = 1'b0;
               ack_valid_d = 1'b1;
               ack_phase_d = phase_q;
               state_d     = ST_SEND_ACK;
            end else begin
               cnt_d = cnt_q - CntWidth'(1);
            end
         end

         ST_WAIT_ISO_DEASSERT: begin
            if (!isolate_ack_i) begin
               ack_valid_d = 1'b1;
               ack_phase_d = phase_q;
               state_d     = ST_SEND_ACK;
            end
         end

         ST_SEND_ACK: begin
            // ack_valid and ack_phase stay frozen until the source half
            // takes the message; isolate/clear keep their levels.
            if (ack_valid_q && ack_ready_i) begin
               ack_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            // Unreachable encodings fall back to the reset picture.
            state_d     = ST_IDLE;
            phase_d     = CLEAR_PHASE_IDLE;
            ack_phase_d = CLEAR_PHASE_IDLE;
            ack_valid_d = 1'b0;
            isolate_d   = 1'b0;
            clear_d     = 1'b0;
            cnt_d       = '0;
         end
      endcase
   end

   // Only one command is ever in flight: ready purely reflects IDLE, which
   // also makes it high throughout reset.
   assign req_ready_o = (state_q == ST_IDLE);
   assign ack_phase_o = ack_phase_q;
   assign ack_valid_o = ack_valid_q;
   assign isolate_o   = isolate_q;
   assign clear_o     = clear_q;

endmodule : cdc_clear_seq_responder
